// File: rtl/uart_frame_pkg.sv
// rtl/uart_frame_pkg.sv - shared constants and types for the UART frame scheduler
//
// Purpose: frame start marker, scheduler state encoding, payload length default
// and the width of the per-frame byte index.
// Ports: none (package).
package uart_frame_pkg;

    localparam logic [7:0] FRAME_START     = 8'hFF;
    localparam int         MAX_LEN_DEFAULT = 4;

    // Byte index covers header (3), payload (up to 4) and an optional checksum byte.
    localparam int BIDX_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FINISH
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with rotating priority pointer
//
// Purpose: picks one requester, starting the search at the priority pointer.
// On an advance strobe with a winner present the pointer moves to winner+1.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (pointer -> 0)
//   req        : request vector
//   advance    : commit the current winner and rotate priority
//   grant      : one-hot winner (combinational), zero when no request
module rr_arbiter #(
    parameter int NREQ = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic            advance,
    output logic [NREQ-1:0] grant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;
    logic          found;
    int            idx;

    always_comb begin
        grant   = '0;
        win_idx = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                win_idx    = PW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance && found) begin
            ptr <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
        end
    end

endmodule

// File: rtl/uart_frame_scheduler.sv
// rtl/uart_frame_scheduler.sv - shares one UART transmitter between NREQ frame sources
//
// Purpose: grants one source round-robin, captures its CMD/LEN/DATA and sends
// FF, CMD, LEN, DATA[0..LEN-1] through the TX_DATA/TX_START/TX_BUSY handshake.
// Optional feature macro UART_FRAME_CHKSUM_EN: appends an XOR checksum byte
// (CMD ^ LEN ^ payload) after the payload.
// Ports:
//   CLOCK_50, RST_N          : clock, asynchronous active-low reset
//   REQ, REQ_CMD/LEN/DATA    : per-source request level and frame fields
//   GRANT, DONE              : one-hot single-cycle pulses per frame
//   BUSY                     : frame in progress (GRANT cycle through DONE cycle)
//   TX_DATA, TX_START        : byte and byte-valid towards the UART
//   TX_BUSY                  : UART transmitting
module uart_frame_scheduler
    import uart_frame_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic               CLOCK_50,
    input  logic               RST_N,
    input  logic [NREQ-1:0]    REQ,
    input  logic [NREQ*8-1:0]  REQ_CMD,
    input  logic [NREQ*3-1:0]  REQ_LEN,
    input  logic [NREQ*32-1:0] REQ_DATA,
    output logic [NREQ-1:0]    GRANT,
    output logic [NREQ-1:0]    DONE,
    output logic               BUSY,
    output logic [7:0]         TX_DATA,
    output logic               TX_START,
    input  logic               TX_BUSY
);

`ifdef UART_FRAME_CHKSUM_EN
    localparam int HDR_LAST = 3;
    logic [7:0] chk_q;
`else
    localparam int HDR_LAST = 2;
`endif

    state_t            state, state_nxt;
    logic [NREQ-1:0]   win;
    logic              advance;
    logic [NREQ-1:0]   owner;
    logic [7:0]        cmd_q;
    logic [2:0]        len_q;
    logic [31:0]       data_q;
    logic [BIDX_W-1:0] idx_q, nxt_idx, last_idx;
    logic [7:0]        sel_cmd, next_byte;
    logic [2:0]        sel_len, len_c;
    logic [31:0]       sel_data;
    logic              is_payload, more;

    assign advance = (state == IDLE) && (|REQ);

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .clk     (CLOCK_50),
        .rst_n   (RST_N),
        .req     (REQ),
        .advance (advance),
        .grant   (win)
    );

    always_comb begin
        sel_cmd  = '0;
        sel_len  = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (win[i]) begin
                sel_cmd  = REQ_CMD[8*i +: 8];
                sel_len  = REQ_LEN[3*i +: 3];
                sel_data = REQ_DATA[32*i +: 32];
            end
        end
        len_c = (int'(sel_len) > MAX_LEN) ? 3'(MAX_LEN) : sel_len;
    end

    // Byte indices: 0 = start marker, 1 = CMD, 2 = LEN, 3.. = payload, then checksum.
    assign last_idx   = BIDX_W'(len_q) + BIDX_W'(HDR_LAST);
    assign nxt_idx    = idx_q + BIDX_W'(1);
    assign more       = (idx_q != last_idx);
    assign is_payload = (nxt_idx >= BIDX_W'(3)) && (nxt_idx <= BIDX_W'(len_q) + BIDX_W'(2));

    // Payload leaves from the bottom of data_q, which shifts down one byte per send.
    always_comb begin
        next_byte = 8'h00;
        if (nxt_idx == BIDX_W'(1)) begin
            next_byte = cmd_q;
        end else if (nxt_idx == BIDX_W'(2)) begin
            next_byte = {5'b0, len_q};
        end else if (is_payload) begin
            next_byte = data_q[7:0];
        end else begin
`ifdef UART_FRAME_CHKSUM_EN
            next_byte = chk_q;
`else
            next_byte = 8'h00;
`endif
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (|REQ) state_nxt = ISSUE;
            ISSUE:   if (TX_BUSY) state_nxt = DRAIN;
            DRAIN:   if (!TX_BUSY) state_nxt = more ? ISSUE : FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Decoded from state so reset clears TX_START/BUSY without waiting for a clock.
    always_comb begin
        BUSY     = (state != IDLE);
        TX_START = (state == ISSUE);
        DONE     = (state == FINISH) ? owner : '0;
    end

    always_ff @(posedge CLOCK_50 or negedge RST_N) begin
        if (!RST_N) begin
            GRANT   <= '0;
            owner   <= '0;
            cmd_q   <= '0;
            len_q   <= '0;
            data_q  <= '0;
            idx_q   <= '0;
            TX_DATA <= 8'h00;
`ifdef UART_FRAME_CHKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            GRANT <= '0;
            case (state)
                IDLE: begin
                    if (advance) begin
                        GRANT   <= win;
                        owner   <= win;
                        cmd_q   <= sel_cmd;
                        len_q   <= len_c;
                        data_q  <= sel_data;
                        idx_q   <= '0;
                        TX_DATA <= FRAME_START;
`ifdef UART_FRAME_CHKSUM_EN
                        chk_q   <= sel_cmd ^ {5'b0, len_c};
`endif
                    end
                end
                DRAIN: begin
                    if (!TX_BUSY && more) begin
                        idx_q   <= nxt_idx;
                        TX_DATA <= next_byte;
                        if (is_payload) begin
                            data_q <= {8'h00, data_q[31:8]};
`ifdef UART_FRAME_CHKSUM_EN
                            chk_q  <= chk_q ^ data_q[7:0];
`endif
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// tb/tb_uart_frame_scheduler.sv - self-checking bench for uart_frame_scheduler
module tb_uart_frame_scheduler;

    localparam int NREQ = 4;
    localparam int MAXL = 4;

    logic               CLOCK_50 = 1'b0;
    logic               RST_N;
    logic [NREQ-1:0]    REQ;
    logic [NREQ*8-1:0]  REQ_CMD;
    logic [NREQ*3-1:0]  REQ_LEN;
    logic [NREQ*32-1:0] REQ_DATA;
    logic [NREQ-1:0]    GRANT, DONE;
    logic               BUSY, TX_START, TX_BUSY;
    logic [7:0]         TX_DATA;

    always #10 CLOCK_50 = ~CLOCK_50;

    uart_frame_scheduler #(.NREQ(NREQ), .MAX_LEN(MAXL)) dut (
        .CLOCK_50 (CLOCK_50),
        .RST_N    (RST_N),
        .REQ      (REQ),
        .REQ_CMD  (REQ_CMD),
        .REQ_LEN  (REQ_LEN),
        .REQ_DATA (REQ_DATA),
        .GRANT    (GRANT),
        .DONE     (DONE),
        .BUSY     (BUSY),
        .TX_DATA  (TX_DATA),
        .TX_START (TX_START),
        .TX_BUSY  (TX_BUSY)
    );

    int checks = 0;
    int errors = 0;

    // Sources
    logic [7:0]  s_cmd  [NREQ];
    logic [2:0]  s_len  [NREQ];
    logic [31:0] s_data [NREQ];
    bit          pend   [NREQ];
    bit          hold   [NREQ];
    bit          rand_mode = 0;

    // Reference model: remaining bytes of the frame in flight
    bit         in_frame = 0, offering = 0;
    int         owner_m = 0, rr_ptr = 0, cool = 0;
    logic [7:0] exp_q[$];

    // Observed DUT history
    logic [7:0] rx_log[$];
    int         grant_log[$];
    int         done_cnt = 0, grant_cnt = 0;

    // UART model
    int u_wait = -1, u_hold = 0;
    int d_min = 0, d_max = 0, h_min = 1, h_max = 1;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic apply_src();
        for (int i = 0; i < NREQ; i++) begin
            REQ[i]              = pend[i];
            REQ_CMD[8*i +: 8]   = s_cmd[i];
            REQ_LEN[3*i +: 3]   = s_len[i];
            REQ_DATA[32*i +: 32] = s_data[i];
        end
    endtask

    task automatic set_src(int i, logic [7:0] c, logic [2:0] l, logic [31:0] d);
        s_cmd[i] = c; s_len[i] = l; s_data[i] = d;
    endtask

    function automatic int pick(logic [NREQ-1:0] r);
        for (int k = 0; k < NREQ; k++)
            if (r[(rr_ptr + k) % NREQ]) return (rr_ptr + k) % NREQ;
        return -1;
    endfunction

    task automatic build(int i);
        int lc;
        logic [7:0] c, b, x;
        exp_q.delete();
        c  = REQ_CMD[8*i +: 8];
        lc = int'(REQ_LEN[3*i +: 3]);
        if (lc > MAXL) lc = MAXL;
        exp_q.push_back(8'hFF);
        exp_q.push_back(c);
        exp_q.push_back(8'(lc));
        x = c ^ 8'(lc);
        for (int k = 0; k < lc; k++) begin
            b = REQ_DATA[32*i + 8*k +: 8];
            exp_q.push_back(b);
            x = x ^ b;
        end
`ifdef UART_FRAME_CHKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    // Called just after each falling edge: advances the model over the rising
    // edge that just happened, using the inputs that were applied at that edge.
    task automatic check_cycle();
        logic [NREQ-1:0] eg, ed;
        bit done_now, eb;
        int w;
        eg = '0; ed = '0; done_now = 0;
        if (!RST_N) begin
            in_frame = 0; offering = 0; rr_ptr = 0; cool = 0;
            exp_q.delete();
        end else if (!in_frame) begin
            if (cool > 0) begin
                cool--;
            end else if (REQ != '0) begin
                w = pick(REQ);
                rr_ptr = (w + 1) % NREQ;
                in_frame = 1; owner_m = w; offering = 1;
                build(w);
                eg[w] = 1'b1;
            end
        end else if (offering) begin
            if (TX_BUSY) begin
                offering = 0;
                rx_log.push_back(TX_DATA);
                void'(exp_q.pop_front());
            end
        end else if (!TX_BUSY) begin
            if (exp_q.size() > 0) begin
                offering = 1;
            end else begin
                done_now = 1; in_frame = 0; cool = 1;
                ed[owner_m] = 1'b1;
            end
        end
        eb = in_frame || done_now;
        chk("GRANT", GRANT, eg);
        chk("DONE", DONE, ed);
        chk("BUSY", BUSY, eb);
        chk("TX_START", TX_START, offering);
        if (offering && exp_q.size() > 0) chk("TX_DATA", TX_DATA, exp_q[0]);
        for (int i = 0; i < NREQ; i++)
            if (GRANT[i]) begin grant_cnt++; grant_log.push_back(i); end
        if (DONE != '0) done_cnt++;
    endtask

    task automatic drive_next();
        for (int i = 0; i < NREQ; i++) begin
            if (GRANT[i] && !hold[i]) begin
                pend[i] = 0;
                if (rand_mode) set_src(i, 8'($urandom), 3'($urandom), $urandom);
            end
            if (rand_mode) begin
                if (!pend[i] && $urandom_range(0, 7) == 0) begin
                    set_src(i, 8'($urandom), 3'($urandom), $urandom);
                    pend[i] = 1;
                end else if (pend[i] && $urandom_range(0, 63) == 0) begin
                    pend[i] = 0;
                end
            end
        end
        apply_src();
        if (!RST_N) begin
            TX_BUSY = 0; u_wait = -1; u_hold = 0;
        end else if (u_hold > 0) begin
            u_hold--;
            if (u_hold == 0) TX_BUSY = 0;
        end else if (u_wait > 0) begin
            u_wait--;
        end else if (u_wait == 0) begin
            TX_BUSY = 1; u_wait = -1; u_hold = $urandom_range(h_min, h_max);
        end else if (TX_START) begin
            int d;
            d = $urandom_range(d_min, d_max);
            if (d == 0) begin
                TX_BUSY = 1; u_hold = $urandom_range(h_min, h_max);
            end else begin
                u_wait = d - 1;
            end
        end
    endtask

    task automatic tick();
        @(negedge CLOCK_50);
        check_cycle();
        drive_next();
    endtask

    task automatic run_until_done(int n, int budget, string nm);
        int c;
        c = 0;
        while (done_cnt < n && c < budget) begin tick(); c++; end
        chk({nm, "_timeout"}, done_cnt >= n, 1);
    endtask

    task automatic clear_logs();
        rx_log.delete(); grant_log.delete(); done_cnt = 0; grant_cnt = 0;
    endtask

    task automatic cmp_bytes(string nm, logic [7:0] e[$]);
        chk({nm, "_count"}, rx_log.size(), e.size());
        for (int k = 0; k < e.size(); k++)
            if (k < rx_log.size()) chk(nm, rx_log[k], e[k]);
    endtask

    task automatic cmp_grants(string nm, int e[$]);
        chk({nm, "_count"}, grant_log.size(), e.size());
        for (int k = 0; k < e.size(); k++)
            if (k < grant_log.size()) chk(nm, grant_log[k], e[k]);
    endtask

    logic [7:0] eb[$];
    int         eg[$];

    initial begin
        RST_N = 0; TX_BUSY = 0;
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 0; hold[i] = 0; set_src(i, 8'h00, 3'd0, 32'h0);
        end
        apply_src();
        tick(); tick();
        chk("rst_GRANT", GRANT, 0);
        chk("rst_DONE", DONE, 0);
        chk("rst_BUSY", BUSY, 0);
        chk("rst_TX_START", TX_START, 0);
        chk("rst_TX_DATA", TX_DATA, 8'h00);
        RST_N = 1;
        tick();

        // All four sources held: grant order from pointer 0
        d_min = 0; d_max = 1; h_min = 1; h_max = 2;
        clear_logs();
        for (int i = 0; i < NREQ; i++) begin
            set_src(i, 8'(8'h10 + i), 3'(i), 32'h44332211); pend[i] = 1; hold[i] = 1;
        end
        begin
            int c; c = 0;
            while (grant_cnt < 5 && c < 2000) begin tick(); c++; end
        end
        for (int i = 0; i < NREQ; i++) begin pend[i] = 0; hold[i] = 0; end
        apply_src();
        run_until_done(5, 500, "rr");
        eg = '{0, 1, 2, 3, 0};
        cmp_grants("rr_order", eg);
        tick(); tick();

        // Basic frame, source 0
        clear_logs();
        set_src(0, 8'h01, 3'd3, 32'h00030201); pend[0] = 1; apply_src();
        run_until_done(1, 500, "basic");
        eb = '{8'hFF, 8'h01, 8'h03, 8'h01, 8'h02, 8'h03};
`ifdef UART_FRAME_CHKSUM_EN
        eb.push_back(8'h02);
`endif
        cmp_bytes("basic_bytes", eb);
        chk("basic_grants", grant_cnt, 1);
        tick(); tick();

        // Header-only frame and clamped length
        clear_logs();
        set_src(1, 8'h04, 3'd0, 32'hFFFFFFFF); pend[1] = 1; apply_src();
        run_until_done(1, 500, "len0");
        eb = '{8'hFF, 8'h04, 8'h00};
`ifdef UART_FRAME_CHKSUM_EN
        eb.push_back(8'h04);
`endif
        cmp_bytes("len0_bytes", eb);
        clear_logs();
        set_src(2, 8'h55, 3'd7, 32'hDDCCBBAA); pend[2] = 1; apply_src();
        run_until_done(1, 500, "len7");
        eb = '{8'hFF, 8'h55, 8'h04, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
`ifdef UART_FRAME_CHKSUM_EN
        eb.push_back(8'h51);
`endif
        cmp_bytes("len7_bytes", eb);

        // Single payload byte (checksum example)
        clear_logs();
        set_src(3, 8'h01, 3'd1, 32'h00000010); pend[3] = 1; apply_src();
        run_until_done(1, 500, "len1");
        eb = '{8'hFF, 8'h01, 8'h01, 8'h10};
`ifdef UART_FRAME_CHKSUM_EN
        eb.push_back(8'h10);
`endif
        cmp_bytes("len1_bytes", eb);

        // Slow UART: acceptance 3 cycles late, busy for 10
        d_min = 3; d_max = 3; h_min = 10; h_max = 10;
        clear_logs();
        set_src(1, 8'hA5, 3'd2, 32'h1234BEEF); pend[1] = 1; apply_src();
        run_until_done(1, 1000, "slow");
        eb = '{8'hFF, 8'hA5, 8'h02, 8'hEF, 8'hBE};
`ifdef UART_FRAME_CHKSUM_EN
        eb.push_back(8'hF6);
`endif
        cmp_bytes("slow_bytes", eb);

        // Reset while payload byte 1 is being offered
        d_min = 1; d_max = 1; h_min = 2; h_max = 2;
        clear_logs();
        set_src(2, 8'h33, 3'd3, 32'h00CCBBAA); pend[2] = 1; apply_src();
        begin
            int c; c = 0;
            while (!(rx_log.size() == 4 && TX_START) && c < 500) begin tick(); c++; end
            chk("rst_mid_reached", rx_log.size() == 4 && TX_START, 1);
        end
        #3 RST_N = 0;
        #1;
        chk("async_TX_START", TX_START, 0);
        chk("async_BUSY", BUSY, 0);
        chk("async_DONE", DONE, 0);
        set_src(1, 8'h61, 3'd0, 32'h0); pend[1] = 1;
        set_src(3, 8'h63, 3'd0, 32'h0); pend[3] = 1;
        apply_src();
        tick(); tick();
        chk("rst_no_done", done_cnt, 0);
        RST_N = 1;
        clear_logs();
        run_until_done(2, 500, "post_rst");
        eg = '{1, 3};
        cmp_grants("post_rst_order", eg);
        if (rx_log.size() > 0) chk("post_rst_first", rx_log[0], 8'hFF);
        else chk("post_rst_first", 32'hFFFF_FFFF, 8'hFF);

        // Randomised traffic
        d_min = 0; d_max = 3; h_min = 1; h_max = 4;
        rand_mode = 1;
        for (int k = 0; k < 6000; k++) tick();
        rand_mode = 0;
        for (int i = 0; i < NREQ; i++) pend[i] = 0;
        apply_src();
        begin
            int c; c = 0;
            while ((in_frame || cool > 0) && c < 500) begin tick(); c++; end
            chk("final_drain", in_frame, 0);
        end
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
